// File: rtl/mac_feeder_pkg.sv
// rtl/mac_feeder_pkg.sv - shared constants, mode encodings and FSM states for mac_feeder
package mac_feeder_pkg;

  localparam int KTAPS  = 9;
  localparam int KTAP_W = 4;

  localparam logic CONV1x1 = 1'b0;
  localparam logic CONV3x3 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Kernel row/column of a 3x3 tap index.
  function automatic logic [1:0] tap_ky(input logic [KTAP_W-1:0] k);
    return 2'(k / 4'd3);
  endfunction

  function automatic logic [1:0] tap_kx(input logic [KTAP_W-1:0] k);
    return 2'(k % 4'd3);
  endfunction

endpackage

// File: rtl/mac_feeder_agen.sv
// rtl/mac_feeder_agen.sv - tap/pixel counters, padding test and stage-0 read requests
module mac_feeder_agen
  import mac_feeder_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue,
  input  logic              mode,
  output logic              last,
  output logic              ifm_rd_en,
  output logic [AW-1:0]     ifm_addr,
  output logic              wgt_rd_en,
  output logic [KTAP_W-1:0] wgt_addr,
  output logic              s0_vld,
  output logic              s0_pad
);

  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  // One guard bit above the range plus a sign bit for the -1 border.
  localparam int SXW = XW + 2;
  localparam int SYW = YW + 2;

  logic [KTAP_W-1:0] k;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;

  logic              k_last, x_last, y_last;
  logic [1:0]        ky, kx;
  logic [SYW-1:0]    iy;
  logic [SXW-1:0]    ix;
  logic              pad;
  logic [AW-1:0]     addr;

  always_comb begin
    k_last = (mode == CONV3x3) ? (k == KTAP_W'(KTAPS-1)) : 1'b1;
    x_last = (ox == XW'(IMG_W-1));
    y_last = (oy == YW'(IMG_H-1));
    last   = k_last && x_last && y_last;

    ky = tap_ky(k);
    kx = tap_kx(k);
    if (mode == CONV3x3) begin
      iy = SYW'(oy) + SYW'(ky) - SYW'(1);
      ix = SXW'(ox) + SXW'(kx) - SXW'(1);
    end else begin
      iy = SYW'(oy);
      ix = SXW'(ox);
    end

    pad  = iy[SYW-1] || ix[SXW-1] || (iy >= SYW'(IMG_H)) || (ix >= SXW'(IMG_W));
    addr = AW'(iy[SYW-2:0]) * AW'(IMG_W) + AW'(ix[SXW-2:0]);
  end

  // Tap wraps first, then column, then row; everything returns to 0 after the last tap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k  <= '0;
      ox <= '0;
      oy <= '0;
    end else if (issue) begin
      if (!k_last) begin
        k <= k + KTAP_W'(1);
      end else begin
        k <= '0;
        if (!x_last) begin
          ox <= ox + XW'(1);
        end else begin
          ox <= '0;
          oy <= y_last ? '0 : oy + YW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifm_rd_en <= 1'b0;
      ifm_addr  <= '0;
      wgt_rd_en <= 1'b0;
      wgt_addr  <= '0;
      s0_vld    <= 1'b0;
      s0_pad    <= 1'b0;
    end else begin
      ifm_rd_en <= issue && !pad;
      wgt_rd_en <= issue;
      s0_vld    <= issue;
      s0_pad    <= issue && pad;
      if (issue && !pad) ifm_addr <= addr;
      if (issue)         wgt_addr <= k;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - job FSM and beat output register feeding mac_kern from IFM/weight buffers
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int WI    = 8,
  parameter int N     = 16,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              is_conv3x3,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [AW-1:0]     ifm_addr,
  input  logic [N*WI-1:0]   ifm_rd_data,
  output logic              wgt_rd_en,
  output logic [KTAP_W-1:0] wgt_addr,
  input  logic [N*WI-1:0]   wgt_rd_data,
  output logic              vld_o,
  output logic [N*WI-1:0]   win,
  output logic [N*WI-1:0]   din,
  output logic              conv_mode_o
);

  state_t state, state_nxt;
  logic   issue, mode_eff, last;
  logic   s0_vld, s0_pad;
  logic   d_vld, d_pad;

  // The start edge itself issues tap 0, so the mode must bypass the latch there.
  assign issue    = ((state == IDLE) && start) || (state == ISSUE);
  assign mode_eff = (state == IDLE) ? is_conv3x3 : conv_mode_o;
  assign busy     = (state == ISSUE) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = last ? DRAIN : ISSUE;
      ISSUE:   if (last)  state_nxt = DRAIN;
      // Leave once the final beat sits in the output register.
      DRAIN:   if (!s0_vld && !d_vld) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conv_mode_o <= CONV1x1;
    end else if ((state == IDLE) && start) begin
      conv_mode_o <= is_conv3x3;
    end else if (state == DONE) begin
      conv_mode_o <= CONV1x1;
    end
  end

  mac_feeder_agen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_agen (
    .clk       (clk),
    .rstn      (rstn),
    .issue     (issue),
    .mode      (mode_eff),
    .last      (last),
    .ifm_rd_en (ifm_rd_en),
    .ifm_addr  (ifm_addr),
    .wgt_rd_en (wgt_rd_en),
    .wgt_addr  (wgt_addr),
    .s0_vld    (s0_vld),
    .s0_pad    (s0_pad)
  );

  // Valid/pad ride alongside the buffer read cycle so they meet the returned data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_vld <= 1'b0;
      d_pad <= 1'b0;
      vld_o <= 1'b0;
      win   <= '0;
      din   <= '0;
    end else begin
      d_vld <= s0_vld;
      d_pad <= s0_pad;
      vld_o <= d_vld;
      if (d_vld) begin
        win <= wgt_rd_data;
        din <= d_pad ? '0 : ifm_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - randomized self-checking bench for mac_feeder against a tap-list model
module tb_mac_feeder;

  localparam int WI = 8;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int DW = N*WI;

  logic          clk = 1'b0;
  logic          rstn, start, is_conv3x3;
  logic          busy, done, ifm_rd_en, wgt_rd_en, vld_o, conv_mode_o;
  logic [AW-1:0] ifm_addr;
  logic [3:0]    wgt_addr;
  logic [DW-1:0] ifm_rd_data = '0;
  logic [DW-1:0] wgt_rd_data = '0;
  logic [DW-1:0] win, din;

  always #5 clk = ~clk;

  mac_feeder #(.WI(WI), .N(N), .IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .is_conv3x3  (is_conv3x3),
    .busy        (busy),
    .done        (done),
    .ifm_rd_en   (ifm_rd_en),
    .ifm_addr    (ifm_addr),
    .ifm_rd_data (ifm_rd_data),
    .wgt_rd_en   (wgt_rd_en),
    .wgt_addr    (wgt_addr),
    .wgt_rd_data (wgt_rd_data),
    .vld_o       (vld_o),
    .win         (win),
    .din         (din),
    .conv_mode_o (conv_mode_o)
  );

  logic [DW-1:0] ifm_mem [W*H];
  logic [DW-1:0] wgt_mem [9];

  always @(posedge clk) begin
    if (ifm_rd_en) ifm_rd_data <= ifm_mem[ifm_addr];
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [DW-1:0] q_win [$];
  logic [DW-1:0] q_din [$];
  int            q_addr [$];
  int            q_wa [$];

  // Expected job: every output pixel in raster order, every kernel tap in order.
  task automatic build_model(input bit mode);
    int taps, iy, ix;
    q_win.delete(); q_din.delete(); q_addr.delete(); q_wa.delete();
    taps = mode ? 9 : 1;
    for (int oy = 0; oy < H; oy++)
      for (int ox = 0; ox < W; ox++)
        for (int t = 0; t < taps; t++) begin
          iy = mode ? oy + t/3 - 1 : oy;
          ix = mode ? ox + t%3 - 1 : ox;
          q_wa.push_back(t);
          q_win.push_back(wgt_mem[t]);
          if (iy >= 0 && iy < H && ix >= 0 && ix < W) begin
            q_addr.push_back(iy*W + ix);
            q_din.push_back(ifm_mem[iy*W + ix]);
          end else begin
            q_din.push_back('0);
          end
        end
  endtask

  function automatic int dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s = 0;
    for (int e = 0; e < N; e++) s += int'($signed(a[e*WI +: WI])) * int'($signed(b[e*WI +: WI]));
    return s;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_vld"}, vld_o, 0);
    check({tag, "_rd"}, {ifm_rd_en, wgt_rd_en}, 0);
    check({tag, "_addr"}, {ifm_addr, wgt_addr}, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_mode"}, conv_mode_o, 0);
  endtask

  task automatic run_job(input bit mode, input int abort_at, input bit inject, input bit ones);
    int beats, first_i, last_i, dones, done_i, acc, taps, total, pix, cy, cx;
    bit aborted;
    taps  = mode ? 9 : 1;
    total = taps*W*H;
    for (int a = 0; a < W*H; a++) ifm_mem[a] = ones ? {N{8'd1}} : DW'($urandom);
    for (int t = 0; t < 9; t++)   wgt_mem[t] = ones ? {N{8'd1}} : DW'($urandom);
    build_model(mode);
    beats = 0; first_i = -1; last_i = -1; dones = 0; done_i = -1; acc = 0; aborted = 0;

    @(negedge clk);
    start = 1'b1;
    is_conv3x3 = mode;
    @(posedge clk); #1;
    start = 1'b0;
    is_conv3x3 = 1'($urandom);

    for (int i = 0; i < 400; i++) begin
      if (ifm_rd_en) begin
        if (q_addr.size() == 0) check("extra_ifm_rd", 1, 0);
        else check("ifm_addr", ifm_addr, q_addr.pop_front());
      end
      if (wgt_rd_en) begin
        if (q_wa.size() == 0) check("extra_wgt_rd", 1, 0);
        else check("wgt_addr", wgt_addr, q_wa.pop_front());
      end
      if (vld_o) begin
        beats++;
        if (first_i < 0) begin
          first_i = i;
          check("first_lat", i, 2);
        end
        last_i = i;
        check("mode_hold", conv_mode_o, mode);
        if (q_win.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("win", win, q_win.pop_front());
          check("din", din, q_din.pop_front());
        end
        if (ones) begin
          acc += dot(win, din);
          if (beats % taps == 0) begin
            pix = beats/taps - 1;
            cy  = 1 + ((pix / W) > 0 ? 1 : 0) + ((pix / W) < H-1 ? 1 : 0);
            cx  = 1 + ((pix % W) > 0 ? 1 : 0) + ((pix % W) < W-1 ? 1 : 0);
            check("mac_sum", acc, N*cy*cx);
            acc = 0;
          end
        end
        if (inject && beats == 5) begin
          start = 1'b1;
          is_conv3x3 = !mode;
        end
      end
      if (done_i >= 0 && i > done_i) check("idle_after", {busy, vld_o, ifm_rd_en, wgt_rd_en, done}, 0);
      if (done) begin
        dones++;
        done_i = i;
        check("done_lat", i, last_i + 1);
        check("busy_at_done", busy, 0);
        if (inject) begin
          start = 1'b1;
          is_conv3x3 = !mode;
        end
      end
      if (abort_at > 0 && beats == abort_at) begin
        rstn = 1'b0;
        #1;
        check_idle_outputs("abort");
        aborted = 1;
        break;
      end
      if (done_i >= 0 && i == done_i + 3) break;
      @(posedge clk); #1;
      start = 1'b0;
    end

    if (aborted) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
    end else begin
      check("beats", beats, total);
      check("last_vld", last_i, total + 1);
      check("done_count", dones, 1);
      check("busy_end", busy, 0);
      check("left_over", q_win.size() + q_addr.size() + q_wa.size(), 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    is_conv3x3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    run_job(1'b0, 0, 1'b0, 1'b0);
    run_job(1'b1, 0, 1'b1, 1'b0);
    run_job(1'b1, 40, 1'b0, 1'b0);
    run_job(1'b0, 0, 1'b0, 1'b0);
    run_job(1'b1, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
